cpe_window_sequencer: RTL and testbench

CPE_WINDOW_SEQUENCER -- requirements
Module: cpe_window_sequencer

---
 rtl/cpe_window_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cpe_window_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpe_window_sequencer.sv
// Window sequencer for a KERNEL_SIZE x KERNEL_SIZE convolution accelerator.
// A weight set is loaded once and kept. Each pixel window is loaded into its own slots.
// The sequencer then pulses mStart on every lane and waits for the accelerator's result.
// The captured result is presented on a valid/ready output port.
module cpe_window_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned TIMEOUT     = 256
) (
  input  logic                                              Clk,
  input  logic                                              Rst,
  input  logic                                              cfg_kernel,
  input  logic [DATA_WIDTH-1:0]                             s_data,
  input  logic                                              s_valid,
  output logic                                              s_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     multiplier_out,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     multiplicand_out,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                mStart,
  output logic                                              direct,
  input  logic                                              finalReady,
  input  logic [DATA_WIDTH-1:0]                             finalAccumulate,
  output logic [DATA_WIDTH-1:0]                             m_data,
  output logic                                              m_valid,
  input  logic                                              m_ready,
  output logic                                              kernel_loaded,
  output logic                                              busy,
  output logic                                              err
);

  localparam int unsigned N    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N - 1);
  localparam logic [CntW-1:0] LastWait = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadP,
    StStart,
    StGuard,
    StWait,
    StOut
  } state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic                    guard_q;
  logic [CntW-1:0]         cnt_q;
  logic [N*DATA_WIDTH-1:0] weight_q;
  logic [N*DATA_WIDTH-1:0] pixel_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic                    m_valid_q;
  logic                    kernel_loaded_q;
  logic                    err_q;

  logic                    accept;

  // Input handshake: the stream is only open while filling slots.
  always_comb begin
    s_ready = (state_q == StLoadW) || (state_q == StLoadP);
    accept  = s_valid && s_ready;
  end

  // Sequencer FSM, slot storage and result capture.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      guard_q         <= 1'b0;
      cnt_q           <= '0;
      weight_q        <= '0;
      pixel_q         <= '0;
      m_data_q        <= '0;
      m_valid_q       <= 1'b0;
      kernel_loaded_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          idx_q <= '0;
          if (cfg_kernel) begin
            // The weight set is invalid as soon as a reload begins.
            kernel_loaded_q <= 1'b0;
            state_q         <= StLoadW;
          end else if (kernel_loaded_q) begin
            state_q <= StLoadP;
          end
        end

        StLoadW: begin
          if (accept) begin
            for (int i = 0; i < int'(N); i++) begin
              if (idx_q == IdxW'(i)) begin
                weight_q[i*DATA_WIDTH +: DATA_WIDTH] <= s_data;
              end
            end
            if (idx_q == LastIdx) begin
              idx_q           <= '0;
              kernel_loaded_q <= 1'b1;
              state_q         <= StIdle;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        StLoadP: begin
          if (accept) begin
            for (int i = 0; i < int'(N); i++) begin
              if (idx_q == IdxW'(i)) begin
                pixel_q[i*DATA_WIDTH +: DATA_WIDTH] <= s_data;
              end
            end
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= StStart;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        StStart: begin
          guard_q <= 1'b0;
          state_q <= StGuard;
        end

        // Two blind cycles: the accelerator's ready is registered and may still
        // be high from the previous window.
        StGuard: begin
          if (guard_q) begin
            cnt_q   <= '0;
            state_q <= StWait;
          end else begin
            guard_q <= 1'b1;
          end
        end

        StWait: begin
          if (finalReady) begin
            m_data_q  <= finalAccumulate;
            m_valid_q <= 1'b1;
            state_q   <= StOut;
          end else if (cnt_q == LastWait) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StOut: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output decode; every bus is driven straight from a register.
  always_comb begin
    multiplier_out   = weight_q;
    multiplicand_out = pixel_q;
    mStart           = {N{state_q == StStart}};
    direct           = 1'b1;
    m_data           = m_data_q;
    m_valid          = m_valid_q;
    kernel_loaded    = kernel_loaded_q;
    busy             = (state_q != StIdle);
    err              = err_q;
  end

endmodule

// File: tb/tb_cpe_window_sequencer.sv
// Bench for cpe_window_sequencer. It models the accelerator and the downstream sink.
// Expected results come from the bench's own weight/pixel arrays. They are pushed into a
// scoreboard and a monitor compares them against the output port.
module tb_cpe_window_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned KS = 3;
  localparam int unsigned N  = KS * KS;
  localparam int unsigned TO = 256;

  typedef logic [N*DW-1:0] bus_t;
  typedef struct {
    int   w;      // WAIT cycles before finalReady; negative means never
    bit   stale;  // hold finalReady high with a wrong sum through the guard
    bus_t wbus;
    bus_t pbus;
  } acc_item_t;
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } sb_item_t;

  localparam logic [N-1:0] Ones = '1;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          cfg_kernel;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  bus_t          multiplier_out;
  bus_t          multiplicand_out;
  logic [N-1:0]  mStart;
  logic          direct;
  logic          finalReady;
  logic [DW-1:0] finalAccumulate;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          kernel_loaded;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_starts = 0;
  int bp_mode  = 0;  // 0 always ready, 1 random, 2 hold off for 10 cycles

  acc_item_t     acc_q[$];
  sb_item_t      sb_q[$];
  logic [DW-1:0] wt[N];
  logic [DW-1:0] px[N];

  cpe_window_sequencer #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(KS),
    .TIMEOUT    (TO)
  ) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .cfg_kernel      (cfg_kernel),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .multiplier_out  (multiplier_out),
    .multiplicand_out(multiplicand_out),
    .mStart          (mStart),
    .direct          (direct),
    .finalReady      (finalReady),
    .finalAccumulate (finalAccumulate),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .kernel_loaded   (kernel_loaded),
    .busy            (busy),
    .err             (err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input bus_t act, input bus_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  function automatic bus_t pack(input logic [DW-1:0] a[N]);
    bus_t r;
    for (int i = 0; i < int'(N); i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  // The reference result is the weighted sum of the window, modulo 2^DW.
  function automatic logic [DW-1:0] dot_model();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < int'(N); i++) s = s + wt[i] * px[i];
    return s;
  endfunction

  function automatic logic [DW-1:0] dot_bus(input bus_t a, input bus_t b);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < int'(N); i++) s = s + a[i*DW +: DW] * b[i*DW +: DW];
    return s;
  endfunction

  // Offer one word and return at the negedge whose following posedge accepts it.
  task automatic send_word(input logic [DW-1:0] d, input bit gaps, output int acc_cyc);
    acc_cyc = -1;
    for (int b = 0; b < 3000; b++) begin
      @(negedge Clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        s_data  = $urandom;
      end else begin
        s_valid = 1'b1;
        s_data  = d;
        if (s_ready) begin
          acc_cyc = cyc;
          return;
        end
      end
    end
    fail_event("send_budget", "word never accepted");
  endtask

  task automatic load_kernel(input bit rand_vals, input bit gaps);
    int a;
    cfg_kernel = 1'b1;
    for (int i = 0; i < int'(N); i++) wt[i] = rand_vals ? DW'($urandom) : DW'(i + 1);
    for (int i = 0; i < int'(N); i++) begin
      send_word(wt[i], gaps, a);
      if (i == 0) begin
        cfg_kernel = 1'b0;
        check("kernel_loaded_low_in_load", bus_t'(kernel_loaded), '0);
      end
    end
    @(negedge Clk);
    s_valid = 1'b0;
    check("kernel_loaded_set", bus_t'(kernel_loaded), bus_t'(1'b1));
    check("idle_after_kernel", bus_t'(busy), '0);
    check("weight_bus", multiplier_out, pack(wt));
  endtask

  task automatic window(input bit gaps, input int w, input bit stale, input bit reload,
                        input bit rand_px, input int bp, output int p);
    acc_item_t it;
    sb_item_t  sb;
    for (int i = 0; i < int'(N); i++) px[i] = rand_px ? DW'($urandom) : DW'(i + 1);
    it.w     = w;
    it.stale = stale;
    it.wbus  = pack(wt);
    it.pbus  = pack(px);
    acc_q.push_back(it);
    for (int i = 0; i < int'(N); i++) begin
      send_word(px[i], gaps, p);
      // cfg_kernel outside IDLE must not divert the pixel load
      if (i == 2) cfg_kernel = 1'b1;
      if (i == 5) cfg_kernel = 1'b0;
    end
    bp_mode = bp;
    if (reload) cfg_kernel = 1'b1;
    if (w >= 0) begin
      sb.data = dot_model();
      sb.cyc  = p + 5 + w;
      sb_q.push_back(sb);
    end
    @(negedge Clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000; t++) begin
      @(negedge Clk);
      if (sb_q.size() == 0 && !m_valid) return;
    end
    fail_event("drain_budget", "results still pending");
  endtask

  // Accelerator model: answers each mStart pulse with the bus dot product.
  initial begin : accel
    acc_item_t     it;
    logic [DW-1:0] sum;
    finalReady      = 1'b0;
    finalAccumulate = '0;
    forever begin
      @(negedge Clk);
      if (Rst && mStart != '0) begin
        n_starts++;
        check("mstart_all_lanes", bus_t'(mStart), bus_t'(Ones));
        if (acc_q.size() == 0) begin
          fail_event("unexpected_mstart", "no window pending");
        end else begin
          it = acc_q.pop_front();
          check("weight_bus_at_start", multiplier_out, it.wbus);
          check("pixel_bus_at_start", multiplicand_out, it.pbus);
          sum = dot_bus(multiplier_out, multiplicand_out);
          for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            if (k == 0) check("mstart_one_cycle", bus_t'(mStart), '0);
            finalReady      = it.stale;
            finalAccumulate = ~sum;
          end
          if (it.w >= 0) begin
            for (int k = 0; k < it.w; k++) begin
              @(negedge Clk);
              finalReady = 1'b0;
            end
            @(negedge Clk);
            finalReady      = 1'b1;
            finalAccumulate = sum;
            check("pixel_bus_stable", multiplicand_out, it.pbus);
            @(negedge Clk);
            finalReady      = 1'b0;
            finalAccumulate = $urandom;
          end else begin
            @(negedge Clk);
            finalReady = 1'b0;
          end
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every new result and drives m_ready.
  initial begin : monitor
    bit            pending = 1'b0;
    bit            hs      = 1'b0;
    int            hold    = 0;
    logic [DW-1:0] held    = '0;
    sb_item_t      it;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        pending = 1'b0;
        hs      = 1'b0;
        hold    = 0;
        continue;
      end
      if (hs) begin
        check("m_valid_drop_after_accept", bus_t'(m_valid), '0);
        pending = 1'b0;
      end else if (pending && !m_valid) begin
        fail_event("m_valid_lost", "result withdrawn without handshake");
        pending = 1'b0;
      end
      if (m_valid && !pending) begin
        pending = 1'b1;
        held    = m_data;
        if (sb_q.size() == 0) begin
          fail_event("unexpected_m_valid", $sformatf("m_data %0h", m_data));
        end else begin
          it = sb_q.pop_front();
          check("m_data", bus_t'(m_data), bus_t'(it.data));
          check("m_valid_latency", bus_t'(cyc), bus_t'(it.cyc));
        end
        if (bp_mode == 2) hold = 10;
      end else if (m_valid) begin
        check("m_data_stable", bus_t'(m_data), bus_t'(held));
      end
      if (m_valid && hold > 0) begin
        m_ready = 1'b0;
        hold--;
        check("s_ready_low_in_out", bus_t'(s_ready), '0);
      end else begin
        m_ready = (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      hs = m_valid && m_ready;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  p;
    int  e_cyc;
    bit  need_load;
    bit  rel;
    bit  seen;
    s_valid    = 1'b0;
    s_data     = '0;
    cfg_kernel = 1'b0;
    #1 Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_s_ready", bus_t'(s_ready), '0);
    check("rst_m_valid", bus_t'(m_valid), '0);
    check("rst_m_data", bus_t'(m_data), '0);
    check("rst_kernel_loaded", bus_t'(kernel_loaded), '0);
    check("rst_err", bus_t'(err), '0);
    check("rst_busy", bus_t'(busy), '0);
    check("rst_mstart", bus_t'(mStart), '0);
    check("rst_direct", bus_t'(direct), bus_t'(1'b1));
    check("rst_weights", multiplier_out, '0);
    check("rst_pixels", multiplicand_out, '0);
    Rst = 1'b1;

    // Without a kernel the sequencer must stay idle and closed.
    s_valid = 1'b1;
    repeat (4) @(negedge Clk);
    check("idle_without_kernel", bus_t'({busy, s_ready}), '0);
    s_valid = 1'b0;

    load_kernel(1'b0, 1'b0);                               // weights 1..9, s_valid held
    window(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, p);               // pixels 1..9, sum 285
    window(1'b0, 2, 1'b0, 1'b0, 1'b1, 2, p);               // 10-cycle backpressure
    window(1'b1, 0, 1'b1, 1'b1, 1'b1, 1, p);               // stale ready, gapped input
    need_load = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (need_load) load_kernel(1'b1, 1'($urandom_range(0, 1)));
      rel = (k % 4 == 3);
      window(1'($urandom_range(0, 1)), int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
             rel, 1'b1, int'($urandom_range(0, 1)), p);
      need_load = rel;
    end
    if (need_load) load_kernel(1'b1, 1'b0);

    // finalReady on the last WAIT cycle still yields a result.
    window(1'b0, int'(TO) - 1, 1'b0, 1'b0, 1'b1, 0, p);
    wait_drain();
    check("no_err_at_limit", bus_t'(err), '0);

    // No finalReady at all: timeout sets err and no result appears.
    window(1'b0, -1, 1'b1, 1'b0, 1'b1, 0, p);
    seen  = 1'b0;
    e_cyc = -1;
    for (int t = 0; t < int'(TO) + 50 && !seen; t++) begin
      @(negedge Clk);
      if (err) begin
        seen  = 1'b1;
        e_cyc = cyc;
        check("idle_after_timeout", bus_t'(busy), '0);
        check("no_result_on_timeout", bus_t'(m_valid), '0);
      end
    end
    check("err_set", bus_t'(seen), bus_t'(1'b1));
    check("err_latency", bus_t'(e_cyc), bus_t'(p + 4 + int'(TO)));

    // Reset in the middle of a pixel load.
    for (int i = 0; i < 4; i++) send_word(DW'($urandom), 1'b0, p);
    @(negedge Clk);
    s_valid = 1'b0;
    Rst     = 1'b0;
    #1;
    check("mid_rst_s_ready", bus_t'(s_ready), '0);
    check("mid_rst_m_valid", bus_t'(m_valid), '0);
    check("mid_rst_m_data", bus_t'(m_data), '0);
    check("mid_rst_kernel_loaded", bus_t'(kernel_loaded), '0);
    check("mid_rst_err", bus_t'(err), '0);
    check("mid_rst_busy", bus_t'(busy), '0);
    check("mid_rst_mstart", bus_t'(mStart), '0);
    check("mid_rst_direct", bus_t'(direct), bus_t'(1'b1));
    check("mid_rst_weights", multiplier_out, '0);
    check("mid_rst_pixels", multiplicand_out, '0);
    repeat (2) @(negedge Clk);
    Rst     = 1'b1;
    s_valid = 1'b1;
    seen    = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge Clk);
      if (s_ready || busy) seen = 1'b1;
    end
    s_valid = 1'b0;
    check("kernel_needed_after_reset", bus_t'(seen), '0);
    check("kernel_loaded_after_reset", bus_t'(kernel_loaded), '0);

    check("scoreboard_empty", bus_t'(sb_q.size()), '0);
    check("accel_queue_empty", bus_t'(acc_q.size()), '0);
    check("mstart_pulse_count", bus_t'(n_starts), bus_t'(21));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
